// File: rtl/mips_pkg.sv
// Shared types and sizes for the instruction/data memory port arbiter.
// Holds the FSM state enum, owner enum, bus widths and default starvation limit.
package mips_pkg;

    localparam int ADDR_W           = 32;
    localparam int DATA_W           = 32;
    localparam int CNT_W            = 4;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts data grants made while fetch is waiting (used with ARB_STARVE_GUARD_EN).
// Ports: clk, rst_n, i_if_grant, i_dm_grant, i_if_req in; o_count (CNT_W) out.
module arb_starve_counter
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_if_grant,
    input  logic             i_dm_grant,
    input  logic             i_if_req,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_if_grant) begin
            r_count <= '0;
        end else if (i_dm_grant) begin
            // Only a grant that made fetch wait counts; saturate at max.
            if (!i_if_req)
                r_count <= '0;
            else if (r_count != '1)
                r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access.
// Ports: clk, rst_n; if_req/if_addr -> if_gnt/if_rvalid/if_rdata;
// dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt/dm_rvalid/dm_rdata;
// mem_req/mem_we/mem_addr/mem_wdata out, mem_ready/mem_rdata in.
// Optional macro ARB_STARVE_GUARD_EN lets fetch win after STARVE_LIMIT
// consecutive data grants; without it data always has priority.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    state_e            r_state;
    owner_e            r_owner;
    logic              r_if_gnt;
    logic              r_dm_gnt;
    logic              r_if_rvalid;
    logic              r_dm_rvalid;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic w_any_req;
    logic w_pick_if;
    logic w_starve_hit;

    assign w_any_req = if_req | dm_req;
    assign w_pick_if = if_req & (~dm_req | w_starve_hit);

`ifdef ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] w_starve_cnt;
    logic             w_if_grant;
    logic             w_dm_grant;

    // Grants decided on this edge (registered gnt appears next cycle).
    assign w_if_grant = (r_state == IDLE) & w_pick_if;
    assign w_dm_grant = (r_state == IDLE) & dm_req & ~w_pick_if;

    arb_starve_counter u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_if_grant (w_if_grant),
        .i_dm_grant (w_dm_grant),
        .i_if_req   (if_req),
        .o_count    (w_starve_cnt)
    );

    assign w_starve_hit = (w_starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign w_starve_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_if_gnt    <= 1'b0;
            r_dm_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_gnt    <= 1'b0;
            r_dm_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state   <= BUSY;
                        r_mem_req <= 1'b1;
                        if (w_pick_if) begin
                            r_owner     <= OWN_IF;
                            r_if_gnt    <= 1'b1;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= if_addr;
                            r_mem_wdata <= '0;
                        end else begin
                            r_owner     <= OWN_DM;
                            r_dm_gnt    <= 1'b1;
                            r_mem_we    <= dm_we;
                            r_mem_addr  <= dm_addr;
                            r_mem_wdata <= dm_wdata;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        r_state   <= DONE;
                        r_mem_req <= 1'b0;
                        if (r_owner == OWN_IF) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= mem_rdata;
                        end else begin
                            r_dm_rvalid <= 1'b1;
                            // Stores return zero data.
                            r_dm_rdata  <= r_mem_we ? '0 : mem_rdata;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign dm_gnt    = r_dm_gnt;
    assign dm_rvalid = r_dm_rvalid;
    assign dm_rdata  = r_dm_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
